input_conditioner: RTL

Upstream stage for the sequence-detector FSM pair: takes the raw push-button and slide-switch, synchronizes and debounces both on the system clock, and emits a clean single-cycle `step` pulse per accepted press plus a debounced `w` level. The `step` pulse and `w` feed the one-hot and binary detectors, which advance one state per step, replacing direct use of the bouncing button as a clock. A wrapping press counter and the conditioner state are exported for LED display and debug.

---
 rtl/input_conditioner.sv | 138 +++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// Push-button and slide-switch conditioner: two-flop synchronizers, a four-state
// button debouncer that emits one step pulse per accepted press, and a switch debouncer.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       sw_raw,
  output logic       step,
  output logic       w,
  output logic [1:0] btn_state,
  output logic [7:0] step_count
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic btn_meta;
  logic btn_s;
  logic sw_meta;
  logic sw_s;

  btn_state_t       state;
  btn_state_t       state_next;
  logic [CNT_W-1:0] bcnt;
  logic [CNT_W-1:0] bcnt_next;
  logic             step_next;
  logic [7:0]       count_next;

  logic [CNT_W-1:0] scnt;
  logic [CNT_W-1:0] scnt_next;
  logic             w_next;

  // Raw inputs are asynchronous to clk, so both pass through two flops before use.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      sw_meta  <= 1'b0;
      sw_s     <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_s    <= btn_meta;
      sw_meta  <= sw_raw;
      sw_s     <= sw_meta;
    end
  end

  always_comb begin
    state_next = state;
    bcnt_next  = bcnt;
    step_next  = 1'b0;
    count_next = step_count;
    case (state)
      RELEASED: begin
        if (btn_s) begin
          state_next = PRESS_PEND;
          bcnt_next  = '0;
        end
      end
      PRESS_PEND: begin
        if (!btn_s) begin
          state_next = RELEASED;
        end else if (bcnt == CNT_LAST) begin
          state_next = HELD;
          step_next  = 1'b1;
          count_next = step_count + 8'd1;
        end else begin
          bcnt_next = bcnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_next = RELEASE_PEND;
          bcnt_next  = '0;
        end
      end
      RELEASE_PEND: begin
        // A bounce back high returns to HELD silently; only a fresh press from RELEASED steps.
        if (btn_s) begin
          state_next = HELD;
        end else if (bcnt == CNT_LAST) begin
          state_next = RELEASED;
        end else begin
          bcnt_next = bcnt + CNT_ONE;
        end
      end
      default: begin
        state_next = RELEASED;
        bcnt_next  = '0;
      end
    endcase
  end

  // Any single cycle where the synchronized switch agrees with w restarts the count.
  always_comb begin
    w_next    = w;
    scnt_next = scnt;
    if (sw_s == w) begin
      scnt_next = '0;
    end else if (scnt == CNT_LAST) begin
      w_next    = sw_s;
      scnt_next = '0;
    end else begin
      scnt_next = scnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RELEASED;
      bcnt       <= '0;
      step       <= 1'b0;
      step_count <= 8'd0;
      w          <= 1'b0;
      scnt       <= '0;
    end else begin
      state      <= state_next;
      bcnt       <= bcnt_next;
      step       <= step_next;
      step_count <= count_next;
      w          <= w_next;
      scnt       <= scnt_next;
    end
  end

  assign btn_state = state;

endmodule
